div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- EX-stage divide sequencer that sits directly upstream of the 32-bit iterative divider core and consumes that core's results.
- Accepts DIV/DIVU requests from EX and converts signed operands to magnitudes.
- Pulses the core's start, stalls the pipeline until the core reports done, then sign-corrects quotient/remainder into a {hi,lo} result for the HI/LO write path.

Parameters:
DATA_W, 32, operand/quotient/remainder width; result is 2*DATA_W.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
div_req  in  1  EX holds high while a DIV/DIVU occupies EX
div_signed  in  1  1=DIV (signed), 0=DIVU; sampled with div_req in IDLE
opdata1  in  DATA_W  dividend
opdata2  in  DATA_W  divisor
annul  in  1  flush/cancel current divide
core_start  out  1  one-cycle start pulse to divider core
core_cancel  out  1  one-cycle abort pulse to divider core
core_a  out  DATA_W  unsigned dividend magnitude to core (registered)
core_b  out  DATA_W  unsigned divisor magnitude to core (registered)
core_done  in  1  core result valid (qualified only in WAIT)
core_q  in  DATA_W  unsigned quotient from core
core_r  in  DATA_W  unsigned remainder from core
result  out  2*DATA_W  {remainder(hi), quotient(lo)}
ready  out  1  result valid
stall_req  out  1  stall request to pipeline control
div_zero  out  1  divide-by-zero flag (feature-dependent)

Behaviour:
- Reset (async, rst=1): state=IDLE. core_start, core_cancel, ready, div_zero = 0. core_a, core_b, result = 0.
- States: IDLE, ZERO, ISSUE, WAIT, DONE.
- IDLE:
  - div_req=1, annul=0, opdata2==0 -> ZERO.
  - div_req=1, annul=0, opdata2!=0 -> ISSUE. Latch:
    - core_a = |opdata1|, core_b = |opdata2| (abs applied only when div_signed=1);
    - neg_q = signed & (sign1^sign2);
    - neg_r = signed & sign1.
  - core_done is ignored in IDLE.
- ISSUE: core_start=1 for exactly this cycle -> WAIT.
- WAIT: hold until core_done=1. Then:
  - lo = neg_q ? -core_q : core_q;
  - hi = neg_r ? -core_r : core_r;
  - register result={hi,lo} -> DONE.
- ZERO: one cycle, then -> DONE with the divide-by-zero result (see Optional Feature).
- DONE: ready=1, result stable. Stay while div_req=1. On div_req=0 -> IDLE, ready=0 next cycle; result is held until the next completion.
- stall_req: combinational.
  - 1 when (IDLE & div_req & ~annul), or in ZERO/ISSUE/WAIT.
  - 0 in DONE and otherwise.
- Latency: request seen in cycle 0 -> ISSUE cycle 1 -> WAIT from cycle 2. core_done in cycle N -> ready and result visible in cycle N+1.
- Annul: in ZERO/ISSUE/WAIT/DONE -> IDLE next cycle, ready=0, div_zero=0.
  - If annul occurs in ISSUE/WAIT: core_cancel=1 for that one cycle.
  - annul takes priority over a simultaneous core_done; the late result is dropped.
- annul=1 in IDLE: request ignored, no stall.
- Signed edge cases:
  - 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
  - |0x80000000| = 0x80000000, treated as unsigned.
- Arithmetic: all negations mod 2^DATA_W.

Optional Feature:
Macro DIV_ZERO_TRAP_EN.
- Defined: ZERO->DONE with result=0 and div_zero=1 held through DONE (cleared on leaving DONE or on annul).
- Undefined: div_zero tied 0. ZERO->DONE with lo=all-ones, hi=opdata1 (as sampled in IDLE); sign correction is not applied.

Test Plan:
- DIVU 43/7, core returns q=6,r=1 three cycles after start -> single core_start pulse with core_a=43, core_b=7; result=0x00000001_00000006; ready=1 the cycle after core_done; stall_req drops with ready.
- DIV -7/2 (0xFFFFFFF9, 0x2), core q=3,r=1 -> core_a=7, core_b=2; result hi=0xFFFFFFFF, lo=0xFFFFFFFD.
- DIV 0x80000000/0xFFFFFFFF, core q=0x80000000,r=0 -> result lo=0x80000000, hi=0.
- DIVU 5/0:
  - macro off: result hi=5, lo=0xFFFFFFFF, div_zero=0, no core_start.
  - macro on: result=0, div_zero=1.
- annul in WAIT, with core_done in the same cycle -> core_cancel pulse, ready stays 0, state IDLE; a new request then completes normally.
- rst asserted mid-WAIT (asynchronous, between edges) -> all outputs 0 immediately; a later core_done is ignored.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// EX-stage divide sequencer: issues to the iterative divider core and sign-corrects results.
// Optional DIV_ZERO_TRAP_EN: divide-by-zero yields result 0 with div_zero flag set.
module div_issue_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                div_req,
  input  logic                div_signed,
  input  logic [DATA_W-1:0]   opdata1,
  input  logic [DATA_W-1:0]   opdata2,
  input  logic                annul,
  output logic                core_start,
  output logic                core_cancel,
  output logic [DATA_W-1:0]   core_a,
  output logic [DATA_W-1:0]   core_b,
  input  logic                core_done,
  input  logic [DATA_W-1:0]   core_q,
  input  logic [DATA_W-1:0]   core_r,
  output logic [2*DATA_W-1:0] result,
  output logic                ready,
  output logic                stall_req,
  output logic                div_zero
);

  typedef enum logic [2:0] {
    IDLE,
    ZERO,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t state;

  logic              neg_q;
  logic              neg_r;
  logic              s1;
  logic              s2;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;
  logic [2*DATA_W-1:0] zero_res;
  logic              zero_flag;

  assign s1    = div_signed & opdata1[DATA_W-1];
  assign s2    = div_signed & opdata2[DATA_W-1];
  assign abs1  = s1 ? ('0 - opdata1) : opdata1;
  assign abs2  = s2 ? ('0 - opdata2) : opdata2;
  assign q_fix = neg_q ? ('0 - core_q) : core_q;
  assign r_fix = neg_r ? ('0 - core_r) : core_r;

`ifdef DIV_ZERO_TRAP_EN
  assign zero_res  = '0;
  assign zero_flag = 1'b1;
`else
  // Raw dividend kept for the MIPS-style x/0 result; no sign fix-up.
  logic [DATA_W-1:0] a_raw;
  assign zero_res  = {a_raw, {DATA_W{1'b1}}};
  assign zero_flag = 1'b0;
`endif

  assign stall_req = (state == IDLE && div_req && !annul) ||
                     (state == ZERO) ||
                     (state == ISSUE) ||
                     (state == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      core_start  <= 1'b0;
      core_cancel <= 1'b0;
      core_a      <= '0;
      core_b      <= '0;
      result      <= '0;
      ready       <= 1'b0;
      div_zero    <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`ifndef DIV_ZERO_TRAP_EN
      a_raw       <= '0;
`endif
    end else begin
      core_start  <= 1'b0;
      core_cancel <= 1'b0;
      unique case (state)
        IDLE: begin
          if (div_req && !annul) begin
`ifndef DIV_ZERO_TRAP_EN
            a_raw <= opdata1;
`endif
            if (opdata2 == '0) begin
              state <= ZERO;
            end else begin
              state      <= ISSUE;
              core_start <= 1'b1;
              core_a     <= abs1;
              core_b     <= abs2;
              neg_q      <= s1 ^ s2;
              neg_r      <= s1;
            end
          end
        end
        ZERO: begin
          if (annul) begin
            state <= IDLE;
          end else begin
            state    <= DONE;
            result   <= zero_res;
            ready    <= 1'b1;
            div_zero <= zero_flag;
          end
        end
        ISSUE: begin
          if (annul) begin
            state       <= IDLE;
            core_cancel <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // annul wins over a coincident done; that result is dropped.
          if (annul) begin
            state       <= IDLE;
            core_cancel <= 1'b1;
          end else if (core_done) begin
            state  <= DONE;
            result <= {r_fix, q_fix};
            ready  <= 1'b1;
          end
        end
        DONE: begin
          if (annul || !div_req) begin
            state    <= IDLE;
            ready    <= 1'b0;
            div_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: vector table, scoreboard and corner sequences.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req;
  logic        div_signed;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic        core_start;
  logic        core_cancel;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_done;
  logic [31:0] core_q;
  logic [31:0] core_r;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;
  logic        div_zero;

  div_issue_ctrl #(.DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .div_req(div_req),
    .div_signed(div_signed),
    .opdata1(opdata1),
    .opdata2(opdata2),
    .annul(annul),
    .core_start(core_start),
    .core_cancel(core_cancel),
    .core_a(core_a),
    .core_b(core_b),
    .core_done(core_done),
    .core_q(core_q),
    .core_r(core_r),
    .result(result),
    .ready(ready),
    .stall_req(stall_req),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] q;
    logic [31:0] r;
    int          dly;
    logic [63:0] exp;
  } vec_t;

  vec_t        vt[8];
  logic [63:0] sbq[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          n;
    logic [63:0] e;
    @(negedge clk);
    div_req    = 1'b1;
    div_signed = v.sgn;
    opdata1    = v.op1;
    opdata2    = v.op2;
    sbq.push_back(v.exp);
    #1 chk("stall_on_req", stall_req, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!core_start && n < 4);
    chk("start_seen", core_start, 1);
    chk("start_latency", n, 1);
    if (!core_start) begin
      div_req = 1'b0;
      void'(sbq.pop_front());
      repeat (4) @(negedge clk);
      return;
    end
    chk("core_a", core_a, v.ea);
    chk("core_b", core_b, v.eb);
    @(negedge clk);
    chk("start_single", core_start, 0);
    repeat (v.dly - 1) @(negedge clk);
    core_done = 1'b1;
    core_q    = v.q;
    core_r    = v.r;
    #1;
    chk("ready_before_done", ready, 0);
    chk("stall_in_wait", stall_req, 1);
    @(negedge clk);
    core_done = 1'b0;
    chk("ready_after_done", ready, 1);
    chk("stall_in_done", stall_req, 0);
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      e = '0;
    end else begin
      e = sbq.pop_front();
      chk("result", result, e);
    end
    div_req = 1'b0;
    @(negedge clk);
    chk("ready_cleared", ready, 0);
    chk("result_held", result, e);
  endtask

  initial begin
    vt[0] = '{1'b0, 32'd43, 32'd7, 32'd43, 32'd7, 32'd6, 32'd1, 3,
              64'h00000001_00000006};
    vt[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'd7, 32'd2, 32'd3, 32'd1, 2,
              64'hFFFFFFFF_FFFFFFFD};
    vt[2] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd1,
              32'h80000000, 32'd0, 1, 64'h00000000_80000000};
    vt[3] = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd2, 32'd3, 32'd1, 4,
              64'h00000001_FFFFFFFD};
    vt[4] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd7, 32'd2, 32'd3, 32'd1, 1,
              64'hFFFFFFFF_00000003};
    vt[5] = '{1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC,
              32'd1, 2, 64'h00000001_7FFFFFFC};
    vt[6] = '{1'b1, 32'd100, 32'd10, 32'd100, 32'd10, 32'd10, 32'd0, 3,
              64'h00000000_0000000A};
    vt[7] = '{1'b1, 32'h80000000, 32'd2, 32'h80000000, 32'd2, 32'h40000000,
              32'd0, 2, 64'h00000000_C0000000};

    rst        = 1'b1;
    div_req    = 1'b0;
    div_signed = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    annul      = 1'b0;
    core_done  = 1'b0;
    core_q     = '0;
    core_r     = '0;
    #3;
    chk("rst_ready", ready, 0);
    chk("rst_result", result, 0);
    chk("rst_core_a", core_a, 0);
    chk("rst_core_b", core_b, 0);
    chk("rst_pulses", {core_start, core_cancel, div_zero}, 0);
    chk("rst_stall", stall_req, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // divide by zero
    @(negedge clk);
    div_req    = 1'b1;
    div_signed = 1'b0;
    opdata1    = 32'd5;
    opdata2    = 32'd0;
    @(negedge clk);
    chk("zero_no_start", core_start, 0);
    chk("zero_stall", stall_req, 1);
    @(negedge clk);
    chk("zero_no_start2", core_start, 0);
    chk("zero_ready", ready, 1);
    chk("zero_stall_done", stall_req, 0);
`ifdef DIV_ZERO_TRAP_EN
    chk("zero_result", result, 64'h0);
    chk("zero_flag", div_zero, 1);
`else
    chk("zero_result", result, 64'h00000005_FFFFFFFF);
    chk("zero_flag", div_zero, 0);
`endif
    div_req = 1'b0;
    @(negedge clk);
    chk("zero_ready_clr", ready, 0);
    chk("zero_flag_clr", div_zero, 0);

    // annul while idle: ignored
    @(negedge clk);
    div_req = 1'b1;
    annul   = 1'b1;
    opdata1 = 32'd9;
    opdata2 = 32'd3;
    #1 chk("annul_idle_stall", stall_req, 0);
    @(negedge clk);
    chk("annul_idle_nostart", core_start, 0);
    div_req = 1'b0;
    annul   = 1'b0;

    // annul in WAIT with coincident done
    @(negedge clk);
    div_req = 1'b1;
    opdata1 = 32'd20;
    opdata2 = 32'd3;
    @(negedge clk);
    chk("aw_start", core_start, 1);
    @(negedge clk);
    annul     = 1'b1;
    core_done = 1'b1;
    core_q    = 32'd6;
    core_r    = 32'd2;
    @(negedge clk);
    annul     = 1'b0;
    core_done = 1'b0;
    div_req   = 1'b0;
    chk("aw_cancel", core_cancel, 1);
    chk("aw_ready", ready, 0);
    #1 chk("aw_idle_stall", stall_req, 0);
    @(negedge clk);
    chk("aw_cancel_single", core_cancel, 0);
    chk("aw_ready2", ready, 0);
    run_vec(vt[1]);

    // async reset mid-WAIT
    @(negedge clk);
    div_req    = 1'b1;
    div_signed = 1'b0;
    opdata1    = 32'd43;
    opdata2    = 32'd7;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst     = 1'b1;
    div_req = 1'b0;
    #1;
    chk("arst_ready", ready, 0);
    chk("arst_result", result, 0);
    chk("arst_core_ab", {core_a, core_b}, 0);
    chk("arst_stall", stall_req, 0);
    @(negedge clk);
    rst       = 1'b0;
    core_done = 1'b1;
    core_q    = 32'd6;
    core_r    = 32'd1;
    @(negedge clk);
    core_done = 1'b0;
    chk("arst_late_done_ready", ready, 0);
    chk("arst_late_done_result", result, 0);
    chk("arst_late_stall", stall_req, 0);

    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
